spi_flash_seq: RTL and testbench
================================

Name: spi_flash_seq

Overview:
- Hardware read sequencer and owner arbiter for the NORA SPI-master register port (CTRL/STAT/DATA), which normally serves CPU accesses at $9F52-$9F54.
- Autonomously issues a flash READ (cmd, 24-bit address, N data bytes) and streams bytes out on a valid/ready port, for boot-time or DMA-style loading.
- While it owns the SPI master, host (CPU register) accesses are blocked. Otherwise host accesses pass straight through.

Parameters:
- READ_CMD, 8'h03, flash read opcode sent first.
- CS_SEL, 8'h01, CTRL value that asserts flash chip select.
- CS_NONE, 8'h00, CTRL value that deselects.
- POLL_TIMEOUT, 1024, maximum cycles waiting for STAT.BUSY=0 per byte.

Ports:
- clk  in  1  system clock, 48 MHz.
- reset  in  1  synchronous reset, active-high.
- host_d_i  in  8  host write data.
- host_d_o  out  8  host read data.
- host_wr_i  in  1  host write strobe.
- host_rd_i  in  1  host read strobe.
- host_cs_ctrl_i, host_cs_stat_i, host_cs_data_i  in  1 each  host register selects.
- spim_d_o  out  8  write data to SPI master.
- spim_d_i  in  8  read data from SPI master; combinational, valid in the strobe cycle.
- spim_wr_o, spim_rd_o  out  1 each  strobes to SPI master.
- spim_cs_ctrl_o, spim_cs_stat_o, spim_cs_data_o  out  1 each  register selects to SPI master.
- start_i  in  1  start pulse; sampled only in IDLE.
- addr_i  in  24  flash byte address; latched at start.
- len_i  in  16  byte count; latched at start.
- rd_data_o  out  8  streamed byte.
- rd_valid_o  out  1  rd_data_o valid.
- rd_ready_i  in  1  consumer accepts.
- abort_i  in  1  abort request.
- busy_o  out  1  sequencer owns the SPI master.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky error (timeout or abort); cleared at next accepted start.

Behaviour:
- SPI master contract:
  - CTRL write selects or deselects.
  - DATA write starts an 8-bit exchange.
  - STAT bit7 = BUSY.
  - DATA read after BUSY=0 returns the received byte.
- Reset: state IDLE, owner=host. All spim strobes/selects 0. rd_valid_o=0, done_o=0, err_o=0, busy_o=0, rd_data_o=0.
- Owner=host (IDLE): spim_* = host_* combinationally (zero latency); host_d_o = spim_d_i.
- Owner=seq (busy_o=1): host strobes are not forwarded; host writes are dropped; host_d_o = 8'h80 (reads as BUSY).
- start_i in IDLE latches addr/len, clears err_o, sets busy_o on the next cycle.
  - A host access in the start cycle still passes through.
  - start_i while busy is ignored.
  - len_i=0: no SPI traffic; done_o pulses 1 cycle after start; busy_o stays 0.
- Strobe rule: the sequencer drives each strobe for exactly 1 cycle, with at least 1 idle cycle between consecutive strobes.
- FSM: IDLE -> SEL -> CMD -> A2 -> A1 -> A0 -> [DUMMY -> FETCH -> OUT]×len -> DESEL -> DONE -> IDLE.
  - SEL: write CTRL = CS_SEL.
  - CMD/A2/A1/A0: write DATA = READ_CMD, addr[23:16], addr[15:8], addr[7:0]; each followed by POLL.
  - POLL: read STAT every other cycle until bit7=0, then resume the saved return state. The timeout counter resets on entry.
  - DUMMY: write DATA=8'hFF, then POLL.
  - FETCH: read DATA and capture spim_d_i into rd_data_o.
  - OUT: hold rd_valid_o=1 and rd_data_o stable until rd_ready_i. On handshake, decrement the remaining count; go to DUMMY if nonzero, else DESEL. No SPI strobes are issued while waiting in OUT.
  - DESEL: write CTRL = CS_NONE.
  - DONE: done_o=1 for 1 cycle; owner returns to host in the same cycle busy_o falls.
- Timeout: if POLL exceeds POLL_TIMEOUT cycles, set err_o and go to DESEL (deselect always issued), then DONE.
- abort_i while busy, in any state other than DESEL/DONE: set err_o and go to DESEL (after any in-flight strobe cycle), then DONE. rd_valid_o drops immediately; the pending byte is discarded. abort_i in IDLE is ignored.
- Simultaneous rd_ready_i and abort_i in OUT: the byte counts as accepted, then the abort is taken.
- Remaining count is 16-bit with no wrap; the address is sent once (flash auto-increments).
- reset mid-operation: immediate return to reset values, with no deselect write (the SPI master is reset by the same reset).

Test Plan:
- Host pass-through in IDLE: host write CTRL=0x01 -> spim_cs_ctrl_o=1, spim_wr_o=1, spim_d_o=0x01 in the same cycle; host read STAT with spim_d_i=0x00 -> host_d_o=0x00.
- Read addr=0x012345, len=2; SPI model BUSY for 3 cycles per byte, returns 0xA5, 0x5A -> DATA writes 03,01,23,45,FF,FF; stream 0xA5 then 0x5A; CTRL writes 01 then 00; done_o pulse, err_o=0.
- Backpressure: rd_ready_i low 20 cycles in OUT -> rd_valid_o held, rd_data_o stable, zero spim strobes during the stall.
- Host blocked: host writes DATA=0x77 and reads STAT while busy -> no spim strobe from host; host_d_o=0x80; transfer unaffected.
- Timeout: BUSY stuck at 1 after CMD -> after POLL_TIMEOUT cycles a CTRL=0x00 write, done_o, err_o=1; next start clears err_o.
- Abort during A1, and len=0 start -> CTRL=0x00 write, done_o, err_o=1; len=0 gives done_o 1 cycle later, no strobes, busy_o never high.

Source files
------------

// File: rtl/spi_flash_seq.sv
// rtl/spi_flash_seq.sv - flash READ sequencer and SPI-master owner arbiter
// Host register accesses pass straight through unless the sequencer owns the SPI master.
module spi_flash_seq #(
    parameter logic [7:0] READ_CMD     = 8'h03,
    parameter logic [7:0] CS_SEL       = 8'h01,
    parameter logic [7:0] CS_NONE      = 8'h00,
    parameter int         POLL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  host_d_i,
    output logic [7:0]  host_d_o,
    input  logic        host_wr_i,
    input  logic        host_rd_i,
    input  logic        host_cs_ctrl_i,
    input  logic        host_cs_stat_i,
    input  logic        host_cs_data_i,
    output logic [7:0]  spim_d_o,
    input  logic [7:0]  spim_d_i,
    output logic        spim_wr_o,
    output logic        spim_rd_o,
    output logic        spim_cs_ctrl_o,
    output logic        spim_cs_stat_o,
    output logic        spim_cs_data_o,
    input  logic        start_i,
    input  logic [23:0] addr_i,
    input  logic [15:0] len_i,
    output logic [7:0]  rd_data_o,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int TW = $clog2(POLL_TIMEOUT + 1);
    localparam logic [TW-1:0] POLL_LIMIT = TW'(POLL_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_SEL, S_GAP, S_CMD, S_A2, S_A1, S_A0, S_DUMMY,
        S_POLL, S_FETCH, S_CAPT, S_OUT, S_DESEL, S_DONE
    } state_t;

    state_t         state, ret;
    logic [23:0]    addr_q;
    logic [15:0]    remain;
    logic [1:0]     poll_ph;
    logic [TW-1:0]  poll_cnt;
    logic [7:0]     seq_d;
    logic           seq_wr, seq_rd, seq_ctrl, seq_stat, seq_data;

    // Owner is the sequencer exactly while busy_o is high.
    assign spim_d_o       = busy_o ? seq_d    : host_d_i;
    assign spim_wr_o      = busy_o ? seq_wr   : host_wr_i;
    assign spim_rd_o      = busy_o ? seq_rd   : host_rd_i;
    assign spim_cs_ctrl_o = busy_o ? seq_ctrl : host_cs_ctrl_i;
    assign spim_cs_stat_o = busy_o ? seq_stat : host_cs_stat_i;
    assign spim_cs_data_o = busy_o ? seq_data : host_cs_data_i;
    assign host_d_o       = busy_o ? 8'h80    : spim_d_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;     ret <= S_IDLE;
            addr_q <= '0;        remain <= '0;
            poll_ph <= '0;       poll_cnt <= '0;
            seq_d <= '0;         seq_wr <= 1'b0;  seq_rd <= 1'b0;
            seq_ctrl <= 1'b0;    seq_stat <= 1'b0; seq_data <= 1'b0;
            rd_data_o <= '0;     rd_valid_o <= 1'b0;
            busy_o <= 1'b0;      done_o <= 1'b0;  err_o <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses; each issuing state sets them for one cycle.
            seq_wr <= 1'b0; seq_rd <= 1'b0;
            seq_ctrl <= 1'b0; seq_stat <= 1'b0; seq_data <= 1'b0;
            done_o <= 1'b0;
            if (busy_o && abort_i && state != S_DESEL && state != S_DONE) begin
                if (state == S_OUT && rd_ready_i) remain <= remain - 16'd1;
                err_o      <= 1'b1;
                rd_valid_o <= 1'b0;
                state      <= S_DESEL;
            end else begin
                case (state)
                    S_IDLE: if (start_i) begin
                        addr_q <= addr_i;
                        remain <= len_i;
                        err_o  <= 1'b0;
                        if (len_i == 16'd0) done_o <= 1'b1;
                        else begin
                            busy_o <= 1'b1;
                            state  <= S_SEL;
                        end
                    end
                    S_SEL: begin
                        seq_wr <= 1'b1; seq_ctrl <= 1'b1; seq_d <= CS_SEL;
                        ret <= S_CMD; state <= S_GAP;
                    end
                    S_GAP: state <= ret;
                    S_CMD, S_A2, S_A1, S_A0, S_DUMMY: begin
                        seq_wr <= 1'b1; seq_data <= 1'b1;
                        poll_ph <= 2'd0; poll_cnt <= '0;
                        state <= S_POLL;
                        case (state)
                            S_CMD:   begin seq_d <= READ_CMD;      ret <= S_A2;    end
                            S_A2:    begin seq_d <= addr_q[23:16]; ret <= S_A1;    end
                            S_A1:    begin seq_d <= addr_q[15:8];  ret <= S_A0;    end
                            S_A0:    begin seq_d <= addr_q[7:0];   ret <= S_DUMMY; end
                            default: begin seq_d <= 8'hFF;         ret <= S_FETCH; end
                        endcase
                    end
                    // Phase 0 is the gap after the data write, 1 issues a STAT read, 2 checks it.
                    S_POLL: begin
                        poll_cnt <= poll_cnt + 1'b1;
                        if (poll_ph == 2'd2 && !spim_d_i[7]) state <= ret;
                        else if (poll_cnt == POLL_LIMIT) begin
                            err_o <= 1'b1;
                            state <= S_DESEL;
                        end else if (poll_ph == 2'd1) begin
                            seq_rd <= 1'b1; seq_stat <= 1'b1;
                            poll_ph <= 2'd2;
                        end else poll_ph <= 2'd1;
                    end
                    S_FETCH: begin
                        seq_rd <= 1'b1; seq_data <= 1'b1;
                        state <= S_CAPT;
                    end
                    S_CAPT: begin
                        rd_data_o  <= spim_d_i;
                        rd_valid_o <= 1'b1;
                        state      <= S_OUT;
                    end
                    S_OUT: if (rd_ready_i) begin
                        rd_valid_o <= 1'b0;
                        remain     <= remain - 16'd1;
                        state      <= (remain == 16'd1) ? S_DESEL : S_DUMMY;
                    end
                    S_DESEL: begin
                        seq_wr <= 1'b1; seq_ctrl <= 1'b1; seq_d <= CS_NONE;
                        state <= S_DONE;
                    end
                    S_DONE: begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_seq.sv
// tb/tb_spi_flash_seq.sv - randomized self-checking bench for spi_flash_seq
module tb_spi_flash_seq;
    localparam int PT = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [7:0]  host_d_i = '0, host_d_o;
    logic        host_wr_i = 0, host_rd_i = 0;
    logic        host_cs_ctrl_i = 0, host_cs_stat_i = 0, host_cs_data_i = 0;
    logic [7:0]  spim_d_o, spim_d_i;
    logic        spim_wr_o, spim_rd_o, spim_cs_ctrl_o, spim_cs_stat_o, spim_cs_data_o;
    logic        start_i = 0;
    logic [23:0] addr_i = '0;
    logic [15:0] len_i = '0;
    logic [7:0]  rd_data_o;
    logic        rd_valid_o, rd_ready_i = 1'b1, abort_i = 0;
    logic        busy_o, done_o, err_o;

    spi_flash_seq dut (
        .clk(clk), .reset(reset),
        .host_d_i(host_d_i), .host_d_o(host_d_o),
        .host_wr_i(host_wr_i), .host_rd_i(host_rd_i),
        .host_cs_ctrl_i(host_cs_ctrl_i), .host_cs_stat_i(host_cs_stat_i), .host_cs_data_i(host_cs_data_i),
        .spim_d_o(spim_d_o), .spim_d_i(spim_d_i),
        .spim_wr_o(spim_wr_o), .spim_rd_o(spim_rd_o),
        .spim_cs_ctrl_o(spim_cs_ctrl_o), .spim_cs_stat_o(spim_cs_stat_o), .spim_cs_data_o(spim_cs_data_o),
        .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
        .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    int n_checks = 0, n_pass = 0;

    // SPI master model: DATA write makes it busy for busy_n cycles; DATA reads pop reply bytes.
    logic [7:0] reply [0:63];
    int   rd_idx = 0, busy_cnt = 0, busy_n = 3;
    bit   stuck = 0, force_en = 0;
    logic [7:0] force_d = '0;

    always_comb begin
        spim_d_i = 8'h00;
        if (force_en)            spim_d_i = force_d;
        else if (spim_cs_stat_o) spim_d_i = {(stuck || busy_cnt != 0), 7'h00};
        else if (spim_cs_data_o) spim_d_i = reply[rd_idx];
    end

    always @(posedge clk) begin
        if (start_i && !busy_o) rd_idx <= 0;
        else if (spim_rd_o && spim_cs_data_o) rd_idx <= rd_idx + 1;
        if (spim_wr_o && spim_cs_data_o) busy_cnt <= busy_n;
        else if (busy_cnt != 0)          busy_cnt <= busy_cnt - 1;
    end

    int ready_mode = 2;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       rd_ready_i = 1'b0;
            1:       rd_ready_i = 1'($urandom_range(0, 1));
            default: rd_ready_i = 1'b1;
        endcase
    end

    logic [7:0] data_wr_q[$], ctrl_wr_q[$], stream_q[$];
    int  strobe_cnt = 0, viol = 0, done_cnt = 0, cyc = 0, first_cmd_cyc = 0, desel_cyc = 0;
    bit  busy_seen = 0, prev_strobe = 0;

    always @(negedge clk) begin
        cyc++;
        if (spim_wr_o && spim_cs_data_o) begin
            if (data_wr_q.size() == 0) first_cmd_cyc = cyc;
            data_wr_q.push_back(spim_d_o);
        end
        if (spim_wr_o && spim_cs_ctrl_o) begin
            ctrl_wr_q.push_back(spim_d_o);
            if (spim_d_o == 8'h00) desel_cyc = cyc;
        end
        if (spim_wr_o || spim_rd_o) strobe_cnt++;
        if ((spim_wr_o || spim_rd_o) && prev_strobe && busy_o) viol++;
        prev_strobe = spim_wr_o || spim_rd_o;
        if (rd_valid_o && rd_ready_i) stream_q.push_back(rd_data_o);
        if (done_o) done_cnt++;
        if (busy_o) busy_seen = 1;
    end

    task automatic clear_logs();
        data_wr_q.delete(); ctrl_wr_q.delete(); stream_q.delete();
        strobe_cnt = 0; viol = 0; done_cnt = 0; busy_seen = 0;
    endtask

    task automatic fill_reply();
        for (int i = 0; i < 64; i++) reply[i] = 8'($urandom);
    endtask

    task automatic do_start(input logic [23:0] a, input logic [15:0] l);
        @(posedge clk); #1;
        addr_i = a; len_i = l; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_o) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({busy_o, done_o, err_o, rd_valid_o} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {busy_o, done_o, err_o, rd_valid_o}); else n_pass++;
        n_checks++; if (rd_data_o !== 8'h00) $display("FAIL reset_rd_data got=%h exp=00", rd_data_o); else n_pass++;
        n_checks++; if ({spim_wr_o, spim_rd_o, spim_cs_ctrl_o, spim_cs_stat_o, spim_cs_data_o} !== 5'b0)
            $display("FAIL reset_spim got=%b exp=00000", {spim_wr_o, spim_rd_o, spim_cs_ctrl_o, spim_cs_stat_o, spim_cs_data_o}); else n_pass++;
        @(posedge clk); #1; reset = 1'b0;
    endtask

    task automatic test_passthrough();
        logic [7:0] v;
        @(posedge clk); #1;
        host_wr_i = 1; host_cs_ctrl_i = 1; host_d_i = 8'h01;
        @(negedge clk);
        n_checks++; if ({spim_wr_o, spim_cs_ctrl_o, spim_d_o} !== {2'b11, 8'h01}) $display("FAIL pass_ctrl_wr got=%b%b/%h exp=11/01", spim_wr_o, spim_cs_ctrl_o, spim_d_o); else n_pass++;
        @(posedge clk); #1;
        host_wr_i = 0; host_cs_ctrl_i = 0; host_rd_i = 1; host_cs_stat_i = 1;
        force_en = 1; force_d = 8'h00;
        @(negedge clk);
        n_checks++; if ({spim_rd_o, spim_cs_stat_o} !== 2'b11) $display("FAIL pass_stat_rd got=%b exp=11", {spim_rd_o, spim_cs_stat_o}); else n_pass++;
        n_checks++; if (host_d_o !== 8'h00) $display("FAIL pass_rd_data got=%h exp=00", host_d_o); else n_pass++;
        v = 8'($urandom); force_d = v; #1;
        n_checks++; if (host_d_o !== v) $display("FAIL pass_rd_rand got=%h exp=%h", host_d_o, v); else n_pass++;
        @(posedge clk); #1;
        host_rd_i = 0; host_cs_stat_i = 0; force_en = 0;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_read(input logic [23:0] a, input logic [15:0] l, input int bn, input int rm, input bit spec_bytes);
        logic [7:0] exp_d[$];
        bit ok;
        busy_n = bn; ready_mode = rm; fill_reply();
        if (spec_bytes) begin reply[0] = 8'hA5; reply[1] = 8'h5A; end
        exp_d = '{8'h03, a[23:16], a[15:8], a[7:0]};
        for (int i = 0; i < int'(l); i++) exp_d.push_back(8'hFF);
        clear_logs();
        do_start(a, l);
        n_checks++; if (err_o !== 1'b0) $display("FAIL read_err_cleared got=%b exp=0", err_o); else n_pass++;
        wait_done(4000, ok);
        n_checks++; if (!ok) $display("FAIL read_done_timeout got=0 exp=1"); else n_pass++;
        @(negedge clk);
        n_checks++; if ({done_o, busy_o, done_cnt} !== {2'b00, 32'd1}) $display("FAIL read_done_pulse got=%b%b/%0d exp=00/1", done_o, busy_o, done_cnt); else n_pass++;
        n_checks++; if (data_wr_q != exp_d) $display("FAIL read_data_writes got=%p exp=%p", data_wr_q, exp_d); else n_pass++;
        n_checks++; if (ctrl_wr_q.size() != 2 || ctrl_wr_q[0] !== 8'h01 || ctrl_wr_q[1] !== 8'h00) $display("FAIL read_ctrl_writes got=%p exp=01,00", ctrl_wr_q); else n_pass++;
        ok = (stream_q.size() == int'(l));
        for (int i = 0; i < stream_q.size() && ok; i++) if (stream_q[i] !== reply[i]) ok = 0;
        n_checks++; if (!ok) $display("FAIL read_stream got=%p exp_len=%0d", stream_q, l); else n_pass++;
        n_checks++; if ({err_o, viol} !== {1'b0, 32'd0}) $display("FAIL read_err_viol got=%b/%0d exp=0/0", err_o, viol); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] d0;
        int s0;
        bit ok, stable;
        busy_n = 2; ready_mode = 0; fill_reply(); clear_logs();
        do_start(24'($urandom), 16'd2);
        ok = 0;
        for (int i = 0; i < 500; i++) begin @(negedge clk); if (rd_valid_o) begin ok = 1; break; end end
        n_checks++; if (!ok) $display("FAIL bp_valid_timeout got=0 exp=1"); else n_pass++;
        d0 = rd_data_o; s0 = strobe_cnt; stable = 1;
        repeat (20) begin @(negedge clk); if (!rd_valid_o || rd_data_o !== d0) stable = 0; end
        n_checks++; if (!stable) $display("FAIL bp_hold got=%b/%h exp=1/%h", rd_valid_o, rd_data_o, d0); else n_pass++;
        n_checks++; if (strobe_cnt != s0) $display("FAIL bp_strobes got=%0d exp=%0d", strobe_cnt, s0); else n_pass++;
        n_checks++; if (d0 !== reply[0]) $display("FAIL bp_byte got=%h exp=%h", d0, reply[0]); else n_pass++;
        ready_mode = 2;
        wait_done(500, ok);
        n_checks++; if (!ok || stream_q.size() != 2 || stream_q[1] !== reply[1]) $display("FAIL bp_stream got=%p exp=%h,%h", stream_q, reply[0], reply[1]); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_host_blocked();
        logic [23:0] a;
        logic [7:0] exp_d[$];
        bit ok, blk;
        a = 24'($urandom); busy_n = 3; ready_mode = 1; fill_reply(); clear_logs();
        exp_d = '{8'h03, a[23:16], a[15:8], a[7:0], 8'hFF, 8'hFF, 8'hFF};
        do_start(a, 16'd3);
        repeat (4) @(posedge clk); #1;
        host_wr_i = 1; host_cs_data_i = 1; host_d_i = 8'h77;
        repeat (6) @(posedge clk); #1;
        host_wr_i = 0; host_cs_data_i = 0; host_rd_i = 1; host_cs_stat_i = 1;
        blk = 1;
        repeat (4) begin @(negedge clk); if (host_d_o !== 8'h80 || !busy_o) blk = 0; end
        n_checks++; if (!blk) $display("FAIL blk_host_rd got=%h/%b exp=80/1", host_d_o, busy_o); else n_pass++;
        @(posedge clk); #1; host_rd_i = 0; host_cs_stat_i = 0;
        wait_done(2000, ok);
        n_checks++; if (!ok || data_wr_q != exp_d) $display("FAIL blk_data_writes got=%p exp=%p", data_wr_q, exp_d); else n_pass++;
        n_checks++; if (stream_q.size() != 3 || stream_q[2] !== reply[2] || viol != 0 || err_o !== 1'b0)
            $display("FAIL blk_stream got=%p viol=%0d err=%b exp_last=%h", stream_q, viol, err_o, reply[2]); else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok;
        int el;
        stuck = 1; ready_mode = 2; clear_logs();
        do_start(24'($urandom), 16'd1);
        wait_done(PT + 200, ok);
        n_checks++; if (!ok || err_o !== 1'b1) $display("FAIL to_done_err got=%b/%b exp=1/1", ok, err_o); else n_pass++;
        n_checks++; if (data_wr_q.size() != 1 || ctrl_wr_q.size() != 2 || ctrl_wr_q[1] !== 8'h00)
            $display("FAIL to_writes got=%p/%p exp=03/01,00", data_wr_q, ctrl_wr_q); else n_pass++;
        el = desel_cyc - first_cmd_cyc;
        n_checks++; if (el < PT || el > PT + 8) $display("FAIL to_latency got=%0d exp=%0d..%0d", el, PT, PT + 8); else n_pass++;
        stuck = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_abort();
        bit ok;
        busy_n = 2; ready_mode = 2; clear_logs();
        do_start(24'($urandom), 16'd2);
        ok = 0;
        for (int i = 0; i < 300; i++) begin @(negedge clk); if (data_wr_q.size() == 3) begin ok = 1; break; end end
        @(posedge clk); #1; abort_i = 1;
        @(posedge clk); #1; abort_i = 0;
        wait_done(100, ok);
        n_checks++; if (!ok || err_o !== 1'b1 || data_wr_q.size() != 3) $display("FAIL abort_a1 got=%b/%b/%0d exp=1/1/3", ok, err_o, data_wr_q.size()); else n_pass++;
        n_checks++; if (ctrl_wr_q.size() != 2 || ctrl_wr_q[1] !== 8'h00 || stream_q.size() != 0 || viol != 0)
            $display("FAIL abort_a1_desel got=%p stream=%0d viol=%0d exp=01,00/0/0", ctrl_wr_q, stream_q.size(), viol); else n_pass++;
        repeat (2) @(negedge clk);
        ready_mode = 0; clear_logs();
        do_start(24'($urandom), 16'd3);
        for (int i = 0; i < 300; i++) begin @(negedge clk); if (rd_valid_o) break; end
        @(posedge clk); #1; abort_i = 1;
        @(posedge clk); #1; abort_i = 0;
        n_checks++; if (rd_valid_o !== 1'b0) $display("FAIL abort_out_valid got=%b exp=0", rd_valid_o); else n_pass++;
        wait_done(100, ok);
        n_checks++; if (!ok || err_o !== 1'b1 || stream_q.size() != 0 || data_wr_q.size() != 5 || ctrl_wr_q.size() != 2)
            $display("FAIL abort_out got=%b/%b/%0d/%0d/%0d exp=1/1/0/5/2", ok, err_o, stream_q.size(), data_wr_q.size(), ctrl_wr_q.size()); else n_pass++;
        ready_mode = 2;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_len0();
        clear_logs();
        do_start(24'($urandom), 16'd0);
        n_checks++; if ({done_o, busy_o, err_o} !== 3'b100) $display("FAIL len0_done got=%b exp=100", {done_o, busy_o, err_o}); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (done_cnt != 1 || strobe_cnt != 0 || busy_seen) $display("FAIL len0_quiet got=%0d/%0d/%b exp=1/0/0", done_cnt, strobe_cnt, busy_seen); else n_pass++;
        @(posedge clk); #1; abort_i = 1;
        @(posedge clk); #1; abort_i = 0;
        repeat (3) @(negedge clk);
        n_checks++; if ({err_o, busy_o, done_o} !== 3'b000) $display("FAIL idle_abort got=%b exp=000", {err_o, busy_o, done_o}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_logs(); busy_n = 2;
        do_start(24'($urandom), 16'd2);
        repeat (15) @(posedge clk);
        #1; reset = 1;
        @(posedge clk); #1; reset = 0;
        n_checks++; if ({busy_o, rd_valid_o, err_o} !== 3'b000) $display("FAIL rst_mid_flags got=%b exp=000", {busy_o, rd_valid_o, err_o}); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++; if (ctrl_wr_q.size() != 1 || done_cnt != 0) $display("FAIL rst_mid_nodesel got=%p done=%0d exp=01/0", ctrl_wr_q, done_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_read(24'h012345, 16'd2, 3, 2, 1'b1);
        for (int k = 0; k < 3; k++)
            test_read(24'($urandom), 16'($urandom_range(1, 6)), $urandom_range(0, 5), 1, 1'b0);
        test_backpressure();
        test_host_blocked();
        test_timeout();
        test_read(24'($urandom), 16'd1, 1, 2, 1'b0);
        test_abort();
        test_len0();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
